// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream XOR stage: byte width,
// controller states and the keystream FIFO pointer-width helper.
package rc4_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One extra pointer bit separates "full" from "empty" when the
    // address bits of the read and write pointers are equal.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rc4_xor_stream_if.sv
// Handshake bundle between the XOR stage and its surroundings.
// master = whoever drives control, keystream, data and dout_ready;
// slave  = the rc4_xor_stream block itself.
interface rc4_xor_stream_if import rc4_pkg::*; #(
    parameter int LEN_W = 16
);
    logic              start;
    logic [LEN_W-1:0]  msg_len;
    logic              flush;
    logic              ks_valid;
    logic [BYTE_W-1:0] ks_data;
    logic              ks_ready;
    logic              din_valid;
    logic [BYTE_W-1:0] din;
    logic              din_ready;
    logic              dout_valid;
    logic [BYTE_W-1:0] dout;
    logic              dout_ready;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  byte_cnt;

    modport master (
        output start, msg_len, flush, ks_valid, ks_data, din_valid, din, dout_ready,
        input  ks_ready, din_ready, dout_valid, dout, busy, done, byte_cnt
    );

    modport slave (
        input  start, msg_len, flush, ks_valid, ks_data, din_valid, din, dout_ready,
        output ks_ready, din_ready, dout_valid, dout, busy, done, byte_cnt
    );
endinterface

// File: rtl/rc4_ks_fifo.sv
// Small keystream FIFO. The head entry is visible combinationally so the
// consumer can XOR it in the same cycle it pops; a pushed byte becomes
// visible only from the following cycle (no bypass path).
module rc4_ks_fifo import rc4_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = BYTE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    // full is derived from registered pointers, so a full FIFO refuses a
    // push even when it is popped in the same cycle. flush wins over both.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr_reg[ADDR_W-1:0]];

    // Pointer update; flush and reset both return to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs an incoming data byte stream with buffered RC4 keystream bytes,
// one keystream byte per data byte, and reports completion after a
// programmed message length. Leftover keystream survives across messages.
module rc4_xor_stream import rc4_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    rc4_xor_stream_if.slave  bus
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]        state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  byte_cnt_reg;
    logic [BYTE_W-1:0] dout_reg;
    logic              dout_valid_reg;
    logic              done_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] ks_head;
    logic              out_free;
    logic              can_fire;
    logic              fire;
    logic              last_byte;

    rc4_ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_ks_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (bus.ks_valid),
        .push_data (bus.ks_data),
        .pop       (fire),
        .head      (ks_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The output register can take a new byte when empty or being drained now.
    assign out_free  = !dout_valid_reg || bus.dout_ready;
    assign can_fire  = (state_reg == RUN) && !fifo_empty && out_free && !bus.flush;
    assign fire      = can_fire && bus.din_valid;
    assign last_byte = (byte_cnt_reg == len_reg - LEN_W'(1));

    assign bus.ks_ready   = !fifo_full;
    assign bus.din_ready  = can_fire;
    assign bus.dout_valid = dout_valid_reg;
    assign bus.dout       = dout_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done       = done_reg;
    assign bus.byte_cnt   = byte_cnt_reg;

    // Message controller, output register and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            byte_cnt_reg   <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else if (bus.flush) begin
            state_reg      <= IDLE;
            dout_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (fire) begin
                dout_reg       <= bus.din ^ ks_head;
                dout_valid_reg <= 1'b1;
                byte_cnt_reg   <= byte_cnt_reg + LEN_W'(1);
            end else if (dout_valid_reg && bus.dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        byte_cnt_reg <= '0;
                        if (bus.msg_len != '0) begin
                            len_reg   <= bus.msg_len;
                            state_reg <= RUN;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire && last_byte) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (dout_valid_reg && bus.dout_ready) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Self-checking bench for rc4_xor_stream: directed scenarios plus random
// traffic scored against a queue-based keystream/data reference model.
module tb_rc4_xor_stream;
    localparam int LEN_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;

    logic [7:0] ks_model[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    rc4_xor_stream_if #(.LEN_W(LEN_W)) bus();

    rc4_xor_stream #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: keystream bytes are consumed in arrival order, each
    // accepted data byte is paired with the oldest unused keystream byte.
    // Inputs only change just after a rising edge, so the negedge view is
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n || bus.flush) begin
            ks_model.delete();
            exp_q.delete();
            obs_q.delete();
        end else begin
            if (bus.dout_valid && bus.dout_ready) begin
                obs_q.push_back(bus.dout);
                $display("out byte %02h", bus.dout);
            end
            if (bus.din_valid && bus.din_ready) begin
                if (ks_model.size() > 0) exp_q.push_back(bus.din ^ ks_model.pop_front());
                else exp_q.push_back(8'hxx);
            end
            if (bus.ks_valid && bus.ks_ready) ks_model.push_back(bus.ks_data);
            if (bus.done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.msg_len = '0; bus.flush = 1'b0;
        bus.ks_valid = 1'b0; bus.ks_data = '0;
        bus.din_valid = 1'b0; bus.din = '0; bus.dout_ready = 1'b1;
    endtask

    task automatic start_msg(input int len);
        bus.start = 1'b1; bus.msg_len = LEN_W'(len);
        tick();
        bus.start = 1'b0;
    endtask

    // Random traffic until done pulses; an exhausted budget is a failure.
    task automatic drive_until_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            bus.ks_valid   = ($urandom_range(0, 3) != 0);
            bus.ks_data    = 8'($urandom);
            bus.din_valid  = ($urandom_range(0, 3) != 0);
            bus.din        = 8'($urandom);
            bus.dout_ready = ($urandom_range(0, 4) != 0);
            tick();
            if (bus.done) seen = 1'b1;
        end
        idle_inputs();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required done=1", budget);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h want 00", bus.dout); end
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy: got %b%b want 00", bus.done, bus.busy); end
        checks++; if (bus.byte_cnt !== 16'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d want 0", bus.byte_cnt); end
        checks++; if (bus.ks_ready !== 1'b1 || bus.din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: ks=%b din=%b want 1 0", bus.ks_ready, bus.din_ready); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_prefetch();
        logic [7:0] ks_v[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] din_v[3] = '{8'hA0, 8'hB0, 8'hC0};
        logic [7:0] exp_v[3] = '{8'hB1, 8'h92, 8'hF3};
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.ks_valid = 1'b1; bus.ks_data = ks_v[i];
            tick();
        end
        bus.ks_valid = 1'b0;
        #1;
        checks++; if (bus.ks_ready !== 1'b0) begin errors++; $display("FAIL prefetch_full: ks_ready=%b want 0", bus.ks_ready); end
        start_msg(3);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL prefetch_busy: got %b want 1", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            bus.din_valid = 1'b1; bus.din = din_v[i];
            #1;
            checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL prefetch_din_ready%0d: got %b want 1", i, bus.din_ready); end
            tick();
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== exp_v[i]) begin errors++; $display("FAIL prefetch_dout%0d: got v=%b %02h want v=1 %02h", i, bus.dout_valid, bus.dout, exp_v[i]); end
        end
        bus.din_valid = 1'b0;
        #1;
        checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL drain_din_ready: got %b want 0", bus.din_ready); end
        tick();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL prefetch_done: done=%b busy=%b dv=%b want 1 0 0", bus.done, bus.busy, bus.dout_valid); end
        checks++; if (bus.byte_cnt !== 16'd3) begin errors++; $display("FAIL prefetch_byte_cnt: got %0d want 3", bus.byte_cnt); end
        tick();
        checks++; if (bus.done !== 1'b0 || done_cnt != d0 + 1) begin errors++; $display("FAIL prefetch_done_once: done=%b pulses=%0d want 0 1", bus.done, done_cnt - d0); end
        // The fourth keystream byte must still be waiting: XOR with 00 exposes it.
        start_msg(1);
        bus.din_valid = 1'b1; bus.din = 8'h00;
        tick();
        bus.din_valid = 1'b0;
        checks++; if (bus.dout !== 8'h44) begin errors++; $display("FAIL prefetch_retained: got %02h want 44", bus.dout); end
        tick(); tick();
    endtask

    task automatic test_starvation();
        exp_q.delete(); obs_q.delete();
        start_msg(2);
        bus.din_valid = 1'b1; bus.din = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL starve_din_ready%0d: got %b want 0", i, bus.din_ready); end
            tick();
        end
        bus.ks_valid = 1'b1; bus.ks_data = 8'h5A;
        #1;
        checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL starve_no_bypass: din_ready=%b want 0", bus.din_ready); end
        tick();
        bus.ks_valid = 1'b0;
        #1;
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_after_push: got %b want 1", bus.din_ready); end
        tick();
        bus.din_valid = 1'b0;
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5) begin errors++; $display("FAIL starve_dout: got v=%b %02h want v=1 a5", bus.dout_valid, bus.dout); end
        drive_until_done(400);
        checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL starve_count: got %0d/%0d want 2", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL starve_byte%0d: got %02h want %02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 8 && bus.ks_ready; i++) begin
            bus.ks_valid = 1'b1; bus.ks_data = 8'($urandom);
            tick();
        end
        bus.ks_valid = 1'b0;
        start_msg(4);
        bus.din_valid = 1'b1; bus.din = 8'($urandom);
        tick();
        bus.dout_ready = 1'b0; bus.din = 8'($urandom);
        held = bus.dout;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready%0d: got %b want 0", i, bus.din_ready); end
            tick();
            checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== held || bus.byte_cnt !== 16'd1) begin errors++; $display("FAIL bp_hold%0d: v=%b dout=%02h cnt=%0d want v=1 %02h 1", i, bus.dout_valid, bus.dout, bus.byte_cnt, held); end
        end
        bus.dout_ready = 1'b1;
        drive_until_done(400);
        checks++; if (obs_q.size() != 4 || exp_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d/%0d want 4", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %02h want %02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len_and_ignored_start();
        exp_q.delete(); obs_q.delete();
        start_msg(0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_len: done=%b busy=%b want 1 0", bus.done, bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse: done=%b want 0", bus.done); end
        start_msg(3);
        start_msg(10);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_start_busy: got %b want 1", bus.busy); end
        drive_until_done(400);
        checks++; if (obs_q.size() != 3 || bus.byte_cnt !== 16'd3) begin errors++; $display("FAIL ign_start_len: bytes=%0d cnt=%0d want 3 3", obs_q.size(), bus.byte_cnt); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ign_start_byte%0d: got %02h want %02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        int d0;
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 8 && bus.ks_ready; i++) begin
            bus.ks_valid = 1'b1; bus.ks_data = 8'($urandom);
            tick();
        end
        bus.ks_valid = 1'b0;
        start_msg(4);
        bus.din_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.din = 8'($urandom);
            tick();
        end
        bus.din_valid = 1'b0;
        checks++; if (obs_q.size() != 1 || exp_q.size() != 2 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_pre_bytes: obs=%0d exp=%0d first %02h want %02h", obs_q.size(), exp_q.size(), obs_q[0], exp_q[0]); end
        d0 = done_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.ks_ready !== 1'b1) begin errors++; $display("FAIL flush_state: busy=%b dv=%b ks_ready=%b want 0 0 1", bus.busy, bus.dout_valid, bus.ks_ready); end
        tick();
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL flush_no_done: pulses=%0d want 0", done_cnt - d0); end
        start_msg(1);
        bus.din_valid = 1'b1;
        #1;
        checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL flush_fifo_empty: din_ready=%b want 0", bus.din_ready); end
        drive_until_done(400);
        checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_restart: obs=%0d exp=%0d byte %02h want %02h", obs_q.size(), exp_q.size(), obs_q[0], exp_q[0]); end
    endtask

    task automatic test_random_stream();
        for (int m = 0; m < 6; m++) begin
            int len = $urandom_range(1, 24);
            exp_q.delete(); obs_q.delete();
            start_msg(len);
            drive_until_done(1000);
            checks++; if (obs_q.size() != len || bus.byte_cnt !== 16'(len)) begin errors++; $display("FAIL rand_len%0d: bytes=%0d cnt=%0d want %0d", m, obs_q.size(), bus.byte_cnt, len); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_msg%0d_byte%0d: got %02h want %02h", m, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.ks_valid = 1'b1; bus.ks_data = 8'($urandom);
        tick();
        bus.ks_valid = 1'b0;
        start_msg(1);
        bus.dout_ready = 1'b0; bus.din_valid = 1'b1; bus.din = 8'($urandom);
        tick();
        bus.din_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL areset_setup: busy=%b dv=%b want 1 1", bus.busy, bus.dout_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.dout !== 8'h00 || bus.byte_cnt !== 16'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL areset_immediate: busy=%b dv=%b dout=%02h cnt=%0d done=%b want all 0", bus.busy, bus.dout_valid, bus.dout, bus.byte_cnt, bus.done); end
        bus.dout_ready = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0 || bus.ks_ready !== 1'b1) begin errors++; $display("FAIL areset_hold: done=%b ks_ready=%b want 0 1", bus.done, bus.ks_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_no_done: done=%b want 0", bus.done); end
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_starvation();
        test_backpressure();
        test_zero_len_and_ignored_start();
        test_flush();
        test_random_stream();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
